// File: rtl/imem_boot_loader.sv
// Boot loader: turns a length/data/checksum byte stream into instruction-memory word writes
// and keeps the processor in reset until a verified image is in place.
module imem_boot_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned WC_W  = ADDR_W + 1;
  localparam logic [16:0] CAP   = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              imem_we_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic [1:0]        err_code_d;
  logic              accept;
  logic              loading_d;
  logic [15:0]       len_full;
  logic              word_last;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_byte, len_q[7:0]};
  assign word_last = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};
  assign loading_d = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CHK};

  // Next-state, datapath and timeout decisions
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    buf_d        = buf_q;
    csum_d       = csum_q;
    tmo_d        = tmo_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    err_code_d   = err_code;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          buf_d      = '0;
          csum_d     = '0;
          tmo_d      = '0;
          err_code_d = 2'b00;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_byte;
          csum_d     = csum_q ^ rx_byte;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ rx_byte;
          if ({1'b0, len_full} > CAP) begin
            state_d    = S_ERR;
            err_code_d = 2'b01;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = {rx_byte, buf_q};
            word_cnt_d   = word_cnt_q + WC_W'(1);
            if (word_last) state_d = S_CHK;
          end else begin
            // Bytes arrive LSB first, so shift new bytes in from the top
            buf_d = {rx_byte, buf_q[23:8]};
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (rx_byte == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CHK}) begin
      if (accept) begin
        tmo_d = '0;
      end else if (TIMEOUT != 0) begin
        if (32'(tmo_q) == TIMEOUT - 32'd1) begin
          state_d    = S_ERR;
          err_code_d = 2'b11;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      rx_ready   <= loading_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_rst    <= (state_d != S_DONE);
      busy       <= loading_d;
      done       <= (state_d == S_DONE);
      err        <= (state_d == S_ERR);
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: frames are scored against a frame-level model
// that decodes length, words and checksum directly from the byte list.
module tb_imem_boot_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_async;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  bit          exp_done;
  logic [1:0]  exp_code;
  int          exp_n;
  bit          exp_len_ok;
  logic [31:0] exp_data[$];
  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];

  localparam logic [47:0] RST_VALS = {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

  imem_boot_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_async(rst_async), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  function automatic logic [47:0] out_vec();
    return {rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err, err_code};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: what a correct loader must end with for this byte list
  task automatic model(input byte_q_t f);
    logic [7:0] x;
    int n;
    exp_data = {};
    n = int'({f[1], f[0]});
    exp_n = n;
    exp_len_ok = (n <= 256);
    if (!exp_len_ok) begin
      exp_done = 1'b0;
      exp_code = 2'b01;
      return;
    end
    for (int k = 0; k < n; k++)
      exp_data.push_back({f[2+4*k+3], f[2+4*k+2], f[2+4*k+1], f[2+4*k]});
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ f[i];
    exp_done = (f[2+4*n] == x);
    exp_code = exp_done ? 2'b00 : 2'b10;
  endtask

  task automatic make_frame(input int n, input bit bad_chk, output byte_q_t f);
    logic [7:0] x;
    logic [7:0] b;
    f = {};
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    if (n > 256) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
    end
    x = 8'h00;
    foreach (f[i]) x = x ^ f[i];
    if (bad_chk) x = x ^ (8'h01 << $urandom_range(7, 0));
    f.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams n_send bytes with random gaps; checks each word strobe one edge after its 4th byte
  task automatic send(input byte_q_t f, input int max_gap, input int n_send, input int start_at);
    logic [31:0] w;
    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      if (rx_ready !== 1'b1) break;
      rx_valid = 1'b1;
      rx_byte  = f[i];
      if (i == start_at) start = 1'b1;
      tick();
      rx_valid = 1'b0;
      start    = 1'b0;
      if (exp_len_ok && i >= 2 && i < 2 + 4 * exp_n && ((i - 2) % 4) == 3) begin
        w = {f[i], f[i-1], f[i-2], f[i-3]};
        n_tests++;
        if (imem_we !== 1'b1 || imem_addr !== 8'((i - 2) / 4) || imem_wdata !== w) begin
          n_fail++;
          $display("FAIL word_strobe byte %0d: we=%b addr=%0h data=%h, want we=1 addr=%0h data=%h",
                   i, imem_we, imem_addr, imem_wdata, 8'((i - 2) / 4), w);
        end
      end
    end
  endtask

  task automatic run_frame(input byte_q_t f, input int max_gap, input int start_at);
    int k;
    model(f);
    got_addr = {};
    got_data = {};
    pulse_start();
    n_tests++;
    if ({busy, done, err, cpu_rst} !== 4'b1001) begin
      n_fail++;
      $display("FAIL rearm: busy/done/err/cpu_rst=%b want 1001", {busy, done, err, cpu_rst});
    end
    send(f, max_gap, f.size(), start_at);
    k = 0;
    while (!(done === 1'b1 || err === 1'b1) && k < 40) begin
      tick();
      k++;
    end
    n_tests++;
    if ({done, err, err_code, cpu_rst, busy} !== {exp_done, !exp_done, exp_code, !exp_done, 1'b0}) begin
      n_fail++;
      $display("FAIL status N=%0d: done/err/code/cpu_rst/busy=%b want %b", exp_n,
               {done, err, err_code, cpu_rst, busy}, {exp_done, !exp_done, exp_code, !exp_done, 1'b0});
    end
    n_tests++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL write_count N=%0d: got %0d want %0d", exp_n, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== 8'(i) || got_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL imem_word %0d: got @%0h=%h want @%0h=%h", i, got_addr[i], got_data[i],
                 8'(i), exp_data[i]);
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (out_vec() !== RST_VALS) begin
      n_fail++;
      $display("FAIL reset_in: got %h want %h", out_vec(), RST_VALS);
    end
    rst_async = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (out_vec() !== RST_VALS) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h want %h", out_vec(), RST_VALS);
    end
  endtask

  task automatic test_basic();
    byte_q_t f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    run_frame(f, 0, -1);
    n_tests++;
    if (got_data.size() != 2 || got_data[0] !== 32'h12345678 || got_data[1] !== 32'hDEADBEEF ||
        done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_image: words=%0d done=%b cpu_rst=%b want 2 words 12345678/deadbeef done=1 cpu_rst=0",
               got_data.size(), done, cpu_rst);
    end
  endtask

  task automatic test_bad_chk();
    byte_q_t f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
    run_frame(f, 0, -1);
    n_tests++;
    if ({err, err_code, cpu_rst, done} !== 5'b1_10_1_0) begin
      n_fail++;
      $display("FAIL bad_chk: err/code/cpu_rst/done=%b want 11010", {err, err_code, cpu_rst, done});
    end
  endtask

  task automatic test_len_err();
    byte_q_t f = '{8'h01, 8'h01, 8'hAA, 8'hBB};
    model(f);
    got_addr = {};
    got_data = {};
    pulse_start();
    send(f, 0, 2, -1);
    n_tests++;
    if ({err, err_code, busy, rx_ready} !== 5'b1_01_0_0) begin
      n_fail++;
      $display("FAIL len_err: err/code/busy/rx_ready=%b want 10100", {err, err_code, busy, rx_ready});
    end
    rx_valid = 1'b1;
    rx_byte  = 8'hAA;
    repeat (4) tick();
    rx_valid = 1'b0;
    n_tests++;
    if (got_data.size() != 0 || err_code !== 2'b01) begin
      n_fail++;
      $display("FAIL len_err_nowrite: writes=%0d code=%b want 0 writes code 01", got_data.size(), err_code);
    end
  endtask

  task automatic test_timeout();
    byte_q_t f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    model(f);
    pulse_start();
    send(f, 0, 3, -1);
    repeat (15) tick();
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: err=%b busy=%b at 15 idle cycles, want err=0 busy=1", err, busy);
    end
    tick();
    n_tests++;
    if ({err, err_code, cpu_rst, done} !== 5'b1_11_1_0) begin
      n_fail++;
      $display("FAIL timeout: err/code/cpu_rst/done=%b want 11110", {err, err_code, cpu_rst, done});
    end
  endtask

  task automatic test_reset_midload();
    byte_q_t f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    model(f);
    pulse_start();
    send(f, 0, 8, -1);
    #3 rst_async = 1'b1;
    #1;
    n_tests++;
    if (out_vec() !== RST_VALS) begin
      n_fail++;
      $display("FAIL reset_midload: got %h want %h", out_vec(), RST_VALS);
    end
    tick();
    rst_async = 1'b0;
    tick();
    run_frame(f, 0, -1);
  endtask

  task automatic test_gaps();
    byte_q_t f;
    for (int r = 0; r < 4; r++) begin
      make_frame($urandom_range(5, 1), 1'b0, f);
      run_frame(f, 3, $urandom_range(f.size() - 1, 1));
    end
    f = '{8'h00, 8'h00, 8'h00};
    run_frame(f, 3, 1);
  endtask

  task automatic test_random();
    byte_q_t f;
    int n;
    for (int r = 0; r < 10; r++) begin
      n = ($urandom_range(7, 0) == 0) ? $urandom_range(400, 257) : $urandom_range(6, 0);
      make_frame(n, $urandom_range(3, 0) == 0, f);
      run_frame(f, $urandom_range(3, 0), -1);
    end
  endtask

  task automatic test_full();
    byte_q_t f;
    make_frame(256, 1'b0, f);
    run_frame(f, 0, -1);
    n_tests++;
    if (got_addr.size() != 256 || got_addr[255] !== 8'hFF || done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_capacity: writes=%0d done=%b want 256 writes ending at ff, done=1",
               got_addr.size(), done);
    end
  endtask

  initial begin
    rst_async = 1'b1;
    start     = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    #12;
    test_reset();
    test_basic();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_reset_midload();
    test_gaps();
    test_random();
    test_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
